adder_arbiter: RTL and testbench

Shares one combinational N-bit carry-lookahead adder between M requesters. Each requester has a valid/ready request port. A round-robin arbiter picks one request per cycle and drives its operands into the adder. The (N+1)-bit sum is registered into a single-entry response buffer, tagged with the winning requester's index. The block sits between the operand producers and the shared adder datapath, and is the only block allowed to drive the adder inputs.

---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/adder_arbiter_rr_arbiter.sv | 33 +++
 rtl/adder_arbiter.sv | 137 +++++++++++++
 tb/tb_adder_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Holds the buffer state encoding, index-width helper and counter width.
package adder_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int BUSY_CNT_W = 16;

    function automatic int calc_idw(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request at or above
// the pointer, wrapping from M-1 back to 0.
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int M   = 4,
    parameter int IDW = calc_idw(M)
) (
    input  logic [M-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [M-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_any_grant
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_id  = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < M; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % M);
            if (!o_any_grant && i_req[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one carry-lookahead adder among M requesters,
// with a single-entry registered response buffer tagged by requester.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int M   = 4,
    localparam int IDW = calc_idw(M)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          req_valid,
    output logic [M-1:0]          req_ready,
    input  logic [M*N-1:0]        req_num1,
    input  logic [M*N-1:0]        req_num2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [N:0]            rsp_result,
    output logic [IDW-1:0]        rsp_id,
    output logic [BUSY_CNT_W-1:0] busy_cycles
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(M - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDW-1:0]          r_ptr;
    logic [N:0]              r_result;
    logic [IDW-1:0]          r_id;
    logic [BUSY_CNT_W-1:0]   r_busy;

    logic [M-1:0]            w_grant;
    logic [IDW-1:0]          w_gid;
    logic                    w_any;
    logic                    w_can_accept;
    logic                    w_xfer;
    logic [IDW-1:0]          w_ptr_nxt;

    logic [N-1:0]            w_a_arr [M];
    logic [N-1:0]            w_b_arr [M];
    logic [N-1:0]            w_a;
    logic [N-1:0]            w_b;
    logic [N-1:0]            w_g;
    logic [N-1:0]            w_p;
    logic [N:0]              w_c;
    logic                    w_term;
    logic [N:0]              w_sum;

    rr_arbiter #(
        .M   (M),
        .IDW (IDW)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_id  (w_gid),
        .o_any_grant (w_any)
    );

    assign w_can_accept = (r_state == EMPTY) || rsp_ready;
    assign req_ready    = (rst || !w_can_accept) ? '0 : w_grant;
    assign w_xfer       = !rst && w_can_accept && w_any;
    assign w_ptr_nxt    = (w_gid == LAST_ID) ? '0 : w_gid + IDW'(1);

    for (genvar i = 0; i < M; i++) begin : g_unpack
        assign w_a_arr[i] = req_num1[i*N +: N];
        assign w_b_arr[i] = req_num2[i*N +: N];
    end

    assign w_a = w_a_arr[w_gid];
    assign w_b = w_b_arr[w_gid];

    // Flat lookahead: every carry is a sum of generate terms
    // propagated through the bits above them, no carry-in.
    always_comb begin
        w_g    = w_a & w_b;
        w_p    = w_a ^ w_b;
        w_c    = '0;
        w_term = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_term;
            end
        end
    end

    assign w_sum = {w_c[N], w_p ^ w_c[N-1:0]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_xfer) w_state_nxt = FULL;
            end
            FULL: begin
                if (w_xfer)         w_state_nxt = FULL;
                else if (rsp_ready) w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_result <= '0;
            r_id     <= '0;
            r_busy   <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr    <= w_ptr_nxt;
                r_result <= w_sum;
                r_id     <= w_gid;
            end
            if (r_state == FULL && !rsp_ready && r_busy != '1) begin
                r_busy <= r_busy + BUSY_CNT_W'(1);
            end
        end
    end

    assign rsp_valid   = (r_state == FULL);
    assign rsp_result  = r_result;
    assign rsp_id      = r_id;
    assign busy_cycles = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised scoreboard bench for adder_arbiter with directed
// scenarios for reset, fairness, backpressure, wrap and max operands.
module tb_adder_arbiter;

    localparam int N   = 8;
    localparam int M   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [M-1:0]     req_valid = '0;
    logic [M-1:0]     req_ready;
    logic [M*N-1:0]   req_num1 = '0;
    logic [M*N-1:0]   req_num2 = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [N:0]       rsp_result;
    logic [IDW-1:0]   rsp_id;
    logic [15:0]      busy_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IDW+N:0] sb [$];
    bit m_full = 1'b0;
    int m_ptr  = 0;
    int m_busy = 0;
    int last_g = -1;

    always #5 clk = ~clk;

    adder_arbiter #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_num1    (req_num1),
        .req_num2    (req_num2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_id      (rsp_id),
        .busy_cycles (busy_cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, check combinational/state outputs, advance model.
    task automatic cyc(input logic r, input logic [M-1:0] v,
                       input logic [M*N-1:0] a, input logic [M*N-1:0] b,
                       input logic rr);
        logic [M-1:0] er;
        logic [N:0]   s;
        logic [N-1:0] x;
        logic [N-1:0] y;
        int g;
        int idx;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_num1  = a;
        req_num2  = b;
        rsp_ready = rr;
        #1;
        er = '0;
        g  = -1;
        if (!r && (!m_full || rr)) begin
            for (int k = 0; k < M; k++) begin
                idx = (m_ptr + k) % M;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("busy_cycles", 32'(busy_cycles), 32'(m_busy));
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_busy = 0;
            sb.delete();
        end else begin
            if (m_full && !rr && m_busy < 65535) m_busy++;
            if (g >= 0) begin
                x = a[g*N +: N];
                y = b[g*N +: N];
                s = (N+1)'(x) + (N+1)'(y);
                sb.push_back({IDW'(g), s});
                m_full = 1'b1;
                m_ptr  = (g + 1) % M;
            end else if (rr) begin
                m_full = 1'b0;
            end
        end
        last_g = g;
    endtask

    initial begin : monitor
        logic [IDW+N:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_spurious: got id %0d result %0h, none expected",
                             rsp_id, rsp_result);
                end else begin
                    e = sb[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e[IDW+N:N+1]));
                    chk("rsp_result", 32'(rsp_result), 32'(e[N:0]));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : stim
        logic [M*N-1:0] A;
        logic [M*N-1:0] B;
        logic [M-1:0]   hv;
        logic [M*N-1:0] ha;
        logic [M*N-1:0] hb;
        logic           r;
        logic           rr;

        A = '0;
        B = '0;
        cyc(1'b1, '0, A, B, 1'b1);
        cyc(1'b1, '0, A, B, 1'b1);
        A[7:0] = 8'hFF;
        B[7:0] = 8'h01;
        cyc(1'b0, 4'b0001, A, B, 1'b1);
        chk("t1_ready", 32'(req_ready), 32'h1);
        cyc(1'b0, 4'b0000, A, B, 1'b1);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_result", 32'(rsp_result), 32'h100);
        chk("t1_id", 32'(rsp_id), 32'h0);

        cyc(1'b1, '0, A, B, 1'b1);
        for (int i = 0; i < M; i++) begin
            A[i*N +: N] = N'(i * 16 + 3);
            B[i*N +: N] = N'(i * 5 + 1);
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 4'hF, A, B, 1'b1);
            chk("fair_order", 32'(req_ready), 32'(1 << (c % M)));
        end
        cyc(1'b0, 4'b0000, A, B, 1'b1);

        A[2*N +: N] = 8'h80;
        B[2*N +: N] = 8'h80;
        cyc(1'b0, 4'b0100, A, B, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 4'b0010, A, B, 1'b0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_result", 32'(rsp_result), 32'h100);
            chk("bp_id", 32'(rsp_id), 32'h2);
        end
        cyc(1'b0, 4'b0010, A, B, 1'b1);
        chk("bp_busy", 32'(busy_cycles), 32'd5);
        chk("bp_refill", 32'(req_ready), 32'h2);

        cyc(1'b0, 4'b0100, A, B, 1'b1);
        cyc(1'b0, 4'b0101, A, B, 1'b1);
        chk("wrap_g0", 32'(req_ready), 32'h1);
        cyc(1'b0, 4'b0101, A, B, 1'b1);
        chk("wrap_g2", 32'(req_ready), 32'h4);

        cyc(1'b0, 4'b0010, A, B, 1'b1);
        cyc(1'b0, 4'b0000, A, B, 1'b0);
        chk("rm_held_id", 32'(rsp_id), 32'h1);
        cyc(1'b1, 4'b0000, A, B, 1'b1);
        cyc(1'b0, 4'b0000, A, B, 1'b0);
        chk("rm_valid", 32'(rsp_valid), 32'h0);
        chk("rm_busy", 32'(busy_cycles), 32'h0);
        cyc(1'b0, 4'hF, A, B, 1'b1);
        chk("rm_ptr0", 32'(req_ready), 32'h1);

        A[3*N +: N] = 8'hFF;
        B[3*N +: N] = 8'hFF;
        cyc(1'b0, 4'b1000, A, B, 1'b1);
        cyc(1'b0, 4'b0000, A, B, 1'b0);
        chk("max_result", 32'(rsp_result), 32'h1FE);
        chk("max_id", 32'(rsp_id), 32'h3);
        cyc(1'b0, 4'b0000, A, B, 1'b1);

        hv = '0;
        ha = '0;
        hb = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom % 200) == 0;
            rr = ($urandom % 4) != 0;
            cyc(r, hv, ha, hb, rr);
            if (last_g >= 0) begin
                hv[last_g]         = 1'($urandom % 2);
                ha[last_g*N +: N]  = N'($urandom);
                hb[last_g*N +: N]  = N'($urandom);
            end
            for (int i = 0; i < M; i++) begin
                if (!hv[i] && ($urandom % 3) == 0) begin
                    hv[i]         = 1'b1;
                    ha[i*N +: N]  = N'($urandom);
                    hb[i*N +: N]  = N'($urandom);
                end
            end
        end

        repeat (4) cyc(1'b0, '0, ha, hb, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
